video_scan_driver: RTL

Parametrised successor to the fixed-mode video driver. It generates horizontal and vertical raster timing with programmable porches, sync widths and polarities, and issues pixel-fetch coordinates scaled down by a power of two. It aligns sync and blanking to a fetch pipeline of configurable latency, and expands packed RGB into the DAC output width. It sits between the framebuffer/renderer (fetch side) and the VGA pins (display side).

---
 rtl/video_pkg.sv | 60 ++++++
 rtl/video_delay_line.sv | 41 ++++
 rtl/video_scan_driver.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared mode constants and helpers for the raster scan driver:
// default 640x480@60 timing, total/width helpers and the channel expander.
package video_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FRONT    = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BACK     = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 33;
    localparam int DEF_H_POL      = 0;
    localparam int DEF_V_POL      = 0;
    localparam int DEF_SCALE      = 1;
    localparam int DEF_REND_W     = 9;
    localparam int DEF_R_IN       = 3;
    localparam int DEF_G_IN       = 3;
    localparam int DEF_B_IN       = 2;
    localparam int DEF_COLOR_OUT  = 4;
    localparam int DEF_FETCH_LAT  = 2;

    function automatic int h_total(input int act, input int front, input int sync, input int back);
        return act + front + sync + back;
    endfunction

    function automatic int v_total(input int act, input int front, input int sync, input int back);
        return act + front + sync + back;
    endfunction

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Output bit k (from the MSB) takes input bit (k mod in_w) from the MSB:
    // replication when widening, plain MSB truncation when narrowing.
    function automatic logic [15:0] expand_channel(input logic [15:0] val, input int in_w,
                                                   input int out_w);
        logic [15:0] res;
        res = 16'd0;
        for (int i = 0; i < 16; i++) begin
            if (i < out_w) begin
                res[out_w - 1 - i] = val[in_w - 1 - (i % in_w)];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// Width/depth parametrised shift register with synchronous clear;
// a depth of zero collapses to a straight wire.
module video_delay_line
    import video_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = clk ^ i_clear;
            assign o_data   = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift one stage per clock, or flush every stage to zero
            always_ff @(posedge clk) begin
                if (i_clear) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= {WIDTH{1'b0}};
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_scan_driver.sv
// Raster timing generator: scaled fetch coordinates out, fetched colour back in,
// sync/blank delayed to match the fetch latency, channels expanded for the DAC.
module video_scan_driver
    import video_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int H_POL       = DEF_H_POL,
    parameter int V_POL       = DEF_V_POL,
    parameter int SCALE_SHIFT = DEF_SCALE,
    parameter int REND_W      = DEF_REND_W,
    parameter int R_IN        = DEF_R_IN,
    parameter int G_IN        = DEF_G_IN,
    parameter int B_IN        = DEF_B_IN,
    parameter int COLOR_OUT   = DEF_COLOR_OUT,
    parameter int FETCH_LAT   = DEF_FETCH_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [R_IN+G_IN+B_IN-1:0]   color,
    output logic [REND_W-1:0]           rendX,
    output logic [REND_W-1:0]           rendY,
    output logic                        rendValid,
    output logic                        frameStart,
    output logic                        lineStart,
    output logic                        hSync,
    output logic                        vSync,
    output logic                        valid,
    output logic [COLOR_OUT-1:0]        red,
    output logic [COLOR_OUT-1:0]        green,
    output logic [COLOR_OUT-1:0]        blue
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int HCW     = clog2(H_TOTAL);
    localparam int VCW     = clog2(V_TOTAL);
    localparam int CIN     = R_IN + G_IN + B_IN;

    localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT_END  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_SYNC_BEG = HCW'(H_ACTIVE + H_FRONT);
    localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [HCW-1:0] H_ONE      = HCW'(1'b1);
    localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT_END  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_SYNC_BEG = VCW'(V_ACTIVE + V_FRONT);
    localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [VCW-1:0] V_ONE      = VCW'(1'b1);
    localparam logic           H_ON       = 1'(H_POL);
    localparam logic           V_ON       = 1'(V_POL);

    generate
        if (((H_ACTIVE - 1) >> SCALE_SHIFT) >= (1 << REND_W)) begin : g_bad_rend_x
            $error("REND_W too narrow for the scaled horizontal active range");
        end
        if (((V_ACTIVE - 1) >> SCALE_SHIFT) >= (1 << REND_W)) begin : g_bad_rend_y
            $error("REND_W too narrow for the scaled vertical active range");
        end
    endgenerate

    logic [HCW-1:0]       r_hcnt;
    logic [VCW-1:0]       r_vcnt;
    logic                 w_active;
    logic                 w_hs_raw;
    logic                 w_vs_raw;
    logic [REND_W-1:0]    r_rend_x;
    logic [REND_W-1:0]    r_rend_y;
    logic                 r_rend_valid;
    logic                 r_line_start;
    logic                 r_frame_start;
    logic                 r_req_hs;
    logic                 r_req_vs;
    logic [2:0]           w_aligned;
    logic [COLOR_OUT-1:0] w_red;
    logic [COLOR_OUT-1:0] w_green;
    logic [COLOR_OUT-1:0] w_blue;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_valid;
    logic [COLOR_OUT-1:0] r_red;
    logic [COLOR_OUT-1:0] r_green;
    logic [COLOR_OUT-1:0] r_blue;

    // Raster counters, parked at the origin while reset or disabled
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_hcnt <= {HCW{1'b0}};
            r_vcnt <= {VCW{1'b0}};
        end else if (r_hcnt == H_LAST) begin
            r_hcnt <= {HCW{1'b0}};
            if (r_vcnt == V_LAST) begin
                r_vcnt <= {VCW{1'b0}};
            end else begin
                r_vcnt <= r_vcnt + V_ONE;
            end
        end else begin
            r_hcnt <= r_hcnt + H_ONE;
            r_vcnt <= r_vcnt;
        end
    end

    assign w_active = (r_hcnt < H_ACT_END) && (r_vcnt < V_ACT_END);
    assign w_hs_raw = (r_hcnt >= H_SYNC_BEG) && (r_hcnt < H_SYNC_END);
    assign w_vs_raw = (r_vcnt >= V_SYNC_BEG) && (r_vcnt < V_SYNC_END);

    // Request stage: fetch coordinates plus the raw flags that must track them
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_rend_x      <= {REND_W{1'b0}};
            r_rend_y      <= {REND_W{1'b0}};
            r_rend_valid  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_req_hs      <= 1'b0;
            r_req_vs      <= 1'b0;
        end else begin
            r_rend_x      <= REND_W'(r_hcnt >> SCALE_SHIFT);
            r_rend_y      <= REND_W'(r_vcnt >> SCALE_SHIFT);
            r_rend_valid  <= w_active;
            r_line_start  <= (r_hcnt == {HCW{1'b0}}) && (r_vcnt < V_ACT_END);
            r_frame_start <= (r_hcnt == {HCW{1'b0}}) && (r_vcnt == {VCW{1'b0}});
            r_req_hs      <= w_hs_raw;
            r_req_vs      <= w_vs_raw;
        end
    end

    // Flags ride alongside the fetch so they meet the colour it returns
    video_delay_line #(
        .WIDTH (3),
        .DEPTH (FETCH_LAT)
    ) u_align (
        .clk     (clk),
        .i_clear (rst || !enable),
        .i_data  ({r_rend_valid, r_req_hs, r_req_vs}),
        .o_data  (w_aligned)
    );

    assign w_red   = COLOR_OUT'(expand_channel(16'(color[CIN-1 -: R_IN]), R_IN, COLOR_OUT));
    assign w_green = COLOR_OUT'(expand_channel(16'(color[G_IN+B_IN-1 -: G_IN]), G_IN, COLOR_OUT));
    assign w_blue  = COLOR_OUT'(expand_channel(16'(color[B_IN-1:0]), B_IN, COLOR_OUT));

    // Display stage: polarity applied, colour forced to black outside the active area
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_hsync <= ~H_ON;
            r_vsync <= ~V_ON;
            r_valid <= 1'b0;
            r_red   <= {COLOR_OUT{1'b0}};
            r_green <= {COLOR_OUT{1'b0}};
            r_blue  <= {COLOR_OUT{1'b0}};
        end else begin
            r_hsync <= w_aligned[1] ? H_ON : ~H_ON;
            r_vsync <= w_aligned[0] ? V_ON : ~V_ON;
            r_valid <= w_aligned[2];
            r_red   <= w_aligned[2] ? w_red   : {COLOR_OUT{1'b0}};
            r_green <= w_aligned[2] ? w_green : {COLOR_OUT{1'b0}};
            r_blue  <= w_aligned[2] ? w_blue  : {COLOR_OUT{1'b0}};
        end
    end

    assign rendX      = r_rend_x;
    assign rendY      = r_rend_y;
    assign rendValid  = r_rend_valid;
    assign lineStart  = r_line_start;
    assign frameStart = r_frame_start;
    assign hSync      = r_hsync;
    assign vSync      = r_vsync;
    assign valid      = r_valid;
    assign red        = r_red;
    assign green      = r_green;
    assign blue       = r_blue;

endmodule
